// File: rtl/regfile_pkg.sv
// Shared definitions for the scoreboarded register file: default widths,
// the hard-wired zero register index and flattened-bus slice helpers.
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int REG_ZERO   = 0;

    function automatic int busWidth(input int ports, input int width);
        return ports * width;
    endfunction

    function automatic int sliceLsb(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits and the running count of pending registers.
// A reservation made on the same edge as a release of that register wins.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                 clock_in,
    input  logic                 reset,
    input  logic                 issueValid,
    input  logic [ADDR_W-1:0]    issueReg,
    input  logic                 regWrite,
    input  logic [ADDR_W-1:0]    writeReg,
    output logic [2**ADDR_W-1:0] busyVec,
    output logic [ADDR_W:0]      pendingCount
);

    logic setHit;
    logic sameReg;
    logic countInc;
    logic countDec;

    always_comb begin
        setHit   = issueValid && (issueReg != ADDR_W'(REG_ZERO));
        sameReg  = setHit && regWrite && (issueReg == writeReg);
        countInc = setHit && !busyVec[issueReg];
        // A release that coincides with a new reservation of that register is absorbed.
        countDec = regWrite && busyVec[writeReg] && !sameReg;
    end

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            busyVec      <= '0;
            pendingCount <= '0;
        end else begin
            if (regWrite) begin
                busyVec[writeReg] <= 1'b0;
            end
            if (setHit) begin
                busyVec[issueReg] <= 1'b1;
            end
            case ({countInc, countDec})
                2'b10:   pendingCount <= pendingCount + (ADDR_W+1)'(1);
                2'b01:   pendingCount <= pendingCount - (ADDR_W+1)'(1);
                default: pendingCount <= pendingCount;
            endcase
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Register file with NUM_RD combinational read ports, one write port and an
// operand-stall scoreboard. Define REGFILE_BYPASS_EN to forward writeback data.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_RD = 2
) (
    input  logic                                  clock_in,
    input  logic                                  reset,
    input  logic [busWidth(NUM_RD, ADDR_W)-1:0]   readReg,
    input  logic [NUM_RD-1:0]                     readEn,
    output logic [busWidth(NUM_RD, DATA_W)-1:0]   readData,
    input  logic                                  issueValid,
    input  logic [ADDR_W-1:0]                     issueReg,
    input  logic                                  regWrite,
    input  logic [ADDR_W-1:0]                     writeReg,
    input  logic [DATA_W-1:0]                     writeData,
    output logic                                  stall,
    output logic [ADDR_W:0]                       pendingCount,
    output logic [2**ADDR_W-1:0]                  busyVec
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] regFile [DEPTH];
    logic [NUM_RD-1:0] portStall;

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regFile[i] <= '0;
            end
        end else if (regWrite && (writeReg != ADDR_W'(REG_ZERO))) begin
            regFile[writeReg] <= writeData;
        end
    end

    regfile_scoreboard #(
        .ADDR_W(ADDR_W)
    ) uScoreboard (
        .clock_in     (clock_in),
        .reset        (reset),
        .issueValid   (issueValid),
        .issueReg     (issueReg),
        .regWrite     (regWrite),
        .writeReg     (writeReg),
        .busyVec      (busyVec),
        .pendingCount (pendingCount)
    );

    for (genvar k = 0; k < NUM_RD; k++) begin : gRead
        localparam int A_LSB = sliceLsb(k, ADDR_W);
        localparam int D_LSB = sliceLsb(k, DATA_W);

        logic [ADDR_W-1:0] idx;
        logic              isZero;
        logic              bypassed;

        assign idx    = readReg[A_LSB +: ADDR_W];
        assign isZero = (idx == ADDR_W'(REG_ZERO));
`ifdef REGFILE_BYPASS_EN
        // Reset gating keeps every port reading zero while reset is held.
        assign bypassed = !reset && regWrite && (writeReg == idx) && !isZero;
`else
        assign bypassed = 1'b0;
`endif
        assign readData[D_LSB +: DATA_W] = isZero   ? '0 :
                                           bypassed ? writeData :
                                                      regFile[idx];
        assign portStall[k] = readEn[k] && busyVec[idx] && !bypassed;
    end

    assign stall = |portStall;

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios plus random traffic
// compared against an array-based reference model of registers and reservations.
module tb_regfile_sb;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NUM_RD = 2;
    localparam int DEPTH  = 32;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                       clock_in;
    logic                       reset;
    logic [NUM_RD*ADDR_W-1:0]   readReg;
    logic [NUM_RD-1:0]          readEn;
    logic [NUM_RD*DATA_W-1:0]   readData;
    logic                       issueValid;
    logic [ADDR_W-1:0]          issueReg;
    logic                       regWrite;
    logic [ADDR_W-1:0]          writeReg;
    logic [DATA_W-1:0]          writeData;
    logic                       stall;
    logic [ADDR_W:0]            pendingCount;
    logic [DEPTH-1:0]           busyVec;

    int checks   = 0;
    int failures = 0;

    logic [DATA_W-1:0] mReg  [DEPTH];
    bit                mBusy [DEPTH];

    regfile_sb #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .NUM_RD(NUM_RD)
    ) dut (
        .clock_in     (clock_in),
        .reset        (reset),
        .readReg      (readReg),
        .readEn       (readEn),
        .readData     (readData),
        .issueValid   (issueValid),
        .issueReg     (issueReg),
        .regWrite     (regWrite),
        .writeReg     (writeReg),
        .writeData    (writeData),
        .stall        (stall),
        .pendingCount (pendingCount),
        .busyVec      (busyVec)
    );

    initial clock_in = 1'b0;
    always #5 clock_in = ~clock_in;

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] port0Data();
        return readData[DATA_W-1:0];
    endfunction

    task automatic modelReset();
        for (int r = 0; r < DEPTH; r++) begin
            mReg[r]  = '0;
            mBusy[r] = 1'b0;
        end
    endtask

    // Reference behaviour at a rising edge: write, release, then reserve (reserve wins).
    task automatic modelUpdate();
        if (reset) begin
            modelReset();
            return;
        end
        if (regWrite && writeReg != 0) mReg[writeReg] = writeData;
        if (regWrite)                  mBusy[writeReg] = 1'b0;
        if (issueValid && issueReg != 0) mBusy[issueReg] = 1'b1;
    endtask

    task automatic checkAll();
        logic [DEPTH-1:0]  expBusy;
        logic [DATA_W-1:0] expData;
        int                expCount;
        bit                expStall;
        bit                fwd;
        int                idx;
        expBusy  = '0;
        expCount = 0;
        expStall = 1'b0;
        for (int r = 0; r < DEPTH; r++) begin
            expBusy[r] = mBusy[r];
            expCount  += int'(mBusy[r]);
        end
        for (int k = 0; k < NUM_RD; k++) begin
            idx = int'(readReg[k*ADDR_W +: ADDR_W]);
            fwd = BYP && regWrite && (int'(writeReg) == idx) && idx != 0;
            if (idx == 0)  expData = '0;
            else if (fwd)  expData = writeData;
            else           expData = mReg[idx];
            checkVal($sformatf("readData%0d", k), readData[k*DATA_W +: DATA_W], expData);
            if (readEn[k] && mBusy[idx] && !fwd) expStall = 1'b1;
        end
        checkVal("stall", stall, expStall);
        checkVal("busyVec", busyVec, expBusy);
        checkVal("pendingCount", pendingCount, expCount);
    endtask

    task automatic probe();
        @(negedge clock_in);
        checkAll();
    endtask

    task automatic commit();
        @(posedge clock_in);
        modelUpdate();
        #1;
    endtask

    task automatic setPort(input int k, input int r, input bit en);
        readReg[k*ADDR_W +: ADDR_W] = ADDR_W'(r);
        readEn[k] = en;
    endtask

    initial begin
        reset      = 1'b1;
        readReg    = '0;
        readEn     = '0;
        issueValid = 1'b0;
        issueReg   = '0;
        regWrite   = 1'b0;
        writeReg   = '0;
        writeData  = '0;
        modelReset();

        #12;
        for (int r = 0; r < DEPTH; r++) begin
            for (int k = 0; k < NUM_RD; k++) setPort(k, r, 1'b1);
            #1;
            for (int k = 0; k < NUM_RD; k++)
                checkVal("rstRead", readData[k*DATA_W +: DATA_W], 0);
        end
        checkVal("rstBusy", busyVec, 0);
        checkVal("rstCount", pendingCount, 0);
        checkVal("rstStall", stall, 0);
        readEn  = '0;
        readReg = '0;
        @(negedge clock_in);
        reset = 1'b0;
        commit();

        // Plain write and read-back; write to r0 is discarded.
        regWrite = 1'b1; writeReg = 5'd5; writeData = 32'hDEADBEEF;
        probe(); commit();
        regWrite = 1'b0; setPort(0, 5, 1'b1);
        probe(); checkVal("r5", port0Data(), 32'hDEADBEEF); commit();
        regWrite = 1'b1; writeReg = 5'd0; writeData = 32'h1234;
        probe(); commit();
        regWrite = 1'b0; setPort(0, 0, 1'b1);
        probe(); checkVal("r0", port0Data(), 0); commit();

        // Reserve r7, then stall on it until writeback.
        setPort(0, 0, 1'b0);
        issueValid = 1'b1; issueReg = 5'd7;
        probe(); commit();
        issueValid = 1'b0; setPort(0, 7, 1'b1);
        probe(); checkVal("r7Stall", stall, 1); checkVal("r7Count", pendingCount, 1); commit();
        regWrite = 1'b1; writeReg = 5'd7; writeData = 32'h55;
        probe();
        checkVal("wbStall", stall, BYP ? 0 : 1);
        checkVal("wbData", port0Data(), BYP ? 32'h55 : 32'h0);
        commit();
        regWrite = 1'b0;
        probe(); checkVal("relStall", stall, 0); checkVal("relData", port0Data(), 32'h55); commit();
        setPort(0, 0, 1'b0);

        // Same-edge reserve and release of a busy register.
        issueValid = 1'b1; issueReg = 5'd9;
        probe(); commit();
        regWrite = 1'b1; writeReg = 5'd9; writeData = 32'hAA;
        probe(); commit();
        issueValid = 1'b0; regWrite = 1'b0; setPort(0, 9, 1'b0);
        probe();
        checkVal("sameBusy", busyVec[9], 1);
        checkVal("sameCount", pendingCount, 1);
        checkVal("sameData", port0Data(), 32'hAA);
        commit();
        regWrite = 1'b1; writeReg = 5'd9; writeData = 32'hAB;
        probe(); commit();
        regWrite = 1'b0;

        // Consecutive reservations, then asynchronous reset mid-sequence.
        issueValid = 1'b1; issueReg = 5'd1;
        probe(); commit();
        issueReg = 5'd2;
        probe(); checkVal("count1", pendingCount, 1); commit();
        issueReg = 5'd3;
        probe(); checkVal("count2", pendingCount, 2); commit();
        issueValid = 1'b0;
        probe(); checkVal("count3", pendingCount, 3);
        #1 reset = 1'b1;
        #1;
        checkVal("asyncCount", pendingCount, 0);
        checkVal("asyncBusy", busyVec, 0);
        checkVal("asyncStall", stall, 0);
        commit();
        reset = 1'b0;

        // Release of a register that is not reserved.
        regWrite = 1'b1; writeReg = 5'd4; writeData = 32'h4444;
        probe(); checkVal("noUnderflow0", pendingCount, 0); commit();
        regWrite = 1'b0; setPort(0, 4, 1'b1);
        probe();
        checkVal("r4Data", port0Data(), 32'h4444);
        checkVal("noUnderflow1", pendingCount, 0);
        commit();

        // Random traffic against the reference model.
        for (int n = 0; n < 400; n++) begin
            readReg    = NUM_RD*ADDR_W'($urandom);
            readEn     = NUM_RD'($urandom);
            issueValid = ($urandom_range(0, 2) == 0);
            issueReg   = ADDR_W'($urandom_range(0, 7));
            regWrite   = ($urandom_range(0, 1) == 0);
            writeReg   = ADDR_W'($urandom_range(0, 7));
            writeData  = $urandom;
            if ($urandom_range(0, 1) == 0) setPort(0, $urandom_range(0, 7), 1'b1);
            probe();
            commit();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised general-purpose register file with N read ports, one write port, and an integrated per-register scoreboard for the pipelined datapath. Decode reads operands and reserves its destination register; writeback writes the result and releases the reservation. The block reports an operand stall when any requested source register is still pending. Register 0 is hard-wired to zero.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, register index width; depth = 2**ADDR_W
- NUM_RD, 2, number of read ports (1..4)

- clock_in  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- readReg  in  NUM_RD*ADDR_W  flattened read indices; port k at [k*ADDR_W +: ADDR_W]
- readEn  in  NUM_RD  port k operand is actually used (qualifies stall)
- readData  out  NUM_RD*DATA_W  flattened read data, port k at [k*DATA_W +: DATA_W]
- issueValid  in  1  decode reserves issueReg this cycle
- issueReg  in  ADDR_W  destination register to mark pending
- regWrite  in  1  writeback valid
- writeReg  in  ADDR_W  writeback destination
- writeData  in  DATA_W  writeback value
- stall  out  1  some enabled read port targets a pending register
- pendingCount  out  ADDR_W+1  number of registers currently pending
- busyVec  out  2**ADDR_W  per-register pending bits, bit 0 always 0

## Operation
- Reads are combinational: readData[k] = regFile[readReg[k]]; index 0 always reads 0.
- Write: on rising clock_in with regWrite=1 and writeReg!=0, regFile[writeReg] <= writeData. Writes to 0 are discarded.
- Scoreboard: busy[r] set at rising edge when issueValid=1, issueReg=r, r!=0. Cleared when regWrite=1, writeReg=r.
- Same-edge set and clear of the same register: set wins; busy stays 1, because a new producer supersedes the old one. The data write still occurs.
- Clear of a register that is not busy: data is written, busy is unchanged, and pendingCount does not underflow.
- Set of a register that is already busy: busy stays 1 and pendingCount is unchanged.
- pendingCount always equals popcount(busy). It is updated incrementally: +1 for a set of a non-busy register, −1 for a clear of a busy register not simultaneously set, net 0 when both apply.
- stall = OR over k of (readEn[k] & busy[readReg[k]] & not bypassed[k]), where bypassed is defined under Configuration. Register 0 never stalls.
- Scoreboard and registers are independent of stall; the upstream holds issueValid low while stalled.

## Timing
- Read latency is 0 cycles (combinational). Write-to-read visibility is the next cycle without bypass, or the same cycle with bypass.
- Reset (async assert): all registers 0, busy all 0, pendingCount 0, stall 0. readData reads 0 on every port.
- Reset deasserted: the first active edge is the next rising clock_in. Reset asserted mid-operation discards all pending reservations and data immediately.

## Configuration
- REGFILE_BYPASS_EN defined:
  - readData[k] = writeData when regWrite=1, writeReg=readReg[k], and readReg[k]!=0.
  - That port is marked bypassed and does not contribute to stall.
- REGFILE_BYPASS_EN undefined:
  - Reads return the stored value only.
  - A port targeting a busy register stalls even during its writeback cycle, and releases the cycle after.

## Structure
- Shared package `regfile_pkg`: DATA_W/ADDR_W defaults, REG_ZERO constant, and the port slice width helpers.
- One sub-module, `regfile_scoreboard`, holds the busy vector, pendingCount, and the set/clear priority logic. The top holds the storage array, read muxes, bypass, and stall reduction.

## Test plan
- Reset applied, then all ports read regs 0..31 → readData=0, busyVec=0, pendingCount=0, stall=0.
- Write 0xDEADBEEF to r5, then read r5 the next cycle → 0xDEADBEEF. Write 0x1234 to r0 → r0 still reads 0.
- issue r7, then readEn[0]=1, readReg[0]=7 → stall=1 and pendingCount=1. Writeback r7=0x55:
  - with bypass: stall=0 that cycle and readData=0x55.
  - without bypass: stall clears one cycle later.
- Same edge issue r9 + writeback r9=0xAA → busy[9]=1, pendingCount unchanged, r9 holds 0xAA.
- issue r1, r2, r3 on consecutive cycles → pendingCount 1, 2, 3. Async reset mid-sequence → pendingCount=0, busyVec=0 without a clock edge.
- Writeback r4 while not busy → r4 updates, pendingCount stays 0 (no underflow).
